data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port. The datapath issues lw/sw/lb/lh/sb/sh/lbu/lhu requests, and this block serves them from an internal word-addressed RAM. It uses a valid/ready request channel, a valid/ready response channel and a configurable number of wait states. It replaces the zero-latency data memory so the datapath can be exercised against a stalling memory.

---
 rtl/data_mem_responder.sv | 163 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Load/store responder for the core's data port: word-addressed RAM behind
// a valid/ready request channel and a valid/ready response channel, with a
// fixed number of wait states between acceptance and response.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_size,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;
    localparam logic [AW-1:0] DEPTH_W  = AW'(DEPTH);
    localparam logic          ZERO_LAT = (LATENCY == 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    logic          lat_we;
    logic [2:0]    lat_size;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;

    logic [31:0]   mem [DEPTH];

    // With zero wait states the response is decided on the accepting edge,
    // so the live request is evaluated there instead of the latched copy.
    logic          op_we;
    logic [2:0]    op_size;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_wdata;

    assign op_we    = (state == IDLE) ? req_we    : lat_we;
    assign op_size  = (state == IDLE) ? req_size  : lat_size;
    assign op_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign op_wdata = (state == IDLE) ? req_wdata : lat_wdata;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    logic enter_resp;
    assign enter_resp = (state == IDLE && req_valid && ZERO_LAT) ||
                        (state == WAIT && cnt == '0);

    logic [IW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [31:0]   wr_word;
    logic          size_ok;
    logic          misalign;
    logic          out_range;
    logic          legal;

    assign word_idx = op_addr[IW+1:2];
    assign rd_word  = mem[word_idx];

    // Legality: funct3 valid for the direction, natural alignment, in range.
    always_comb begin
        size_ok = 1'b0;
        case (op_size)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = !op_we;
            default:                size_ok = 1'b0;
        endcase
        misalign  = (op_size[1:0] == 2'b01 && op_addr[0]) ||
                    (op_size[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
        out_range = ({2'b00, op_addr[AW-1:2]} >= DEPTH_W);
        legal     = size_ok && !misalign && !out_range;
    end

    // Lane extraction with sign/zero extension for loads.
    always_comb begin
        rd_byte   = rd_word[{op_addr[1:0], 3'b000} +: 8];
        rd_half   = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = '0;
        case (op_size)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_byte};
            3'b101:  load_data = {16'd0, rd_half};
            default: load_data = '0;
        endcase
    end

    // Read-modify-write merge so partial stores touch only their bytes.
    always_comb begin
        wr_word = rd_word;
        case (op_size[1:0])
            2'b00: wr_word[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
            2'b01: begin
                if (op_addr[1]) wr_word[31:16] = op_wdata[15:0];
                else            wr_word[15:0]  = op_wdata[15:0];
            end
            2'b10:   wr_word = op_wdata;
            default: wr_word = rd_word;
        endcase
    end

    // Control FSM, request latch and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_size   <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    lat_we    <= req_we;
                    lat_size  <= req_size;
                    lat_addr  <= req_addr;
                    lat_wdata <= req_wdata;
                    if (ZERO_LAT) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - 1'b1;
                end
                RESP: if (resp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                resp_err   <= !legal;
                resp_rdata <= (legal && !op_we) ? load_data : '0;
            end
        end
    end

    // Store commit happens only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && legal && op_we) mem[word_idx] <= wr_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance, directed
// scenarios plus random traffic checked against a byte-array memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv[2], rwe[2], rrdy[2], rvld[2], rrr[2], rerr[2];
    logic [2:0]  rsz[2];
    logic [31:0] ra[2], rwd[2], rdat[2];

    int  total = 0;
    int  bad   = 0;
    time acc_t, hs_t;

    logic [7:0] rmem [2][4*DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2), .AW(32)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(rv[0]), .req_ready(rrdy[0]), .req_we(rwe[0]), .req_size(rsz[0]),
        .req_addr(ra[0]), .req_wdata(rwd[0]),
        .resp_valid(rvld[0]), .resp_ready(rrr[0]), .resp_rdata(rdat[0]), .resp_err(rerr[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(0), .AW(32)) u_l0 (
        .clk(clk), .rst(rst),
        .req_valid(rv[1]), .req_ready(rrdy[1]), .req_we(rwe[1]), .req_size(rsz[1]),
        .req_addr(ra[1]), .req_wdata(rwd[1]),
        .resp_valid(rvld[1]), .resp_ready(rrr[1]), .resp_rdata(rdat[1]), .resp_err(rerr[1])
    );

    // Reference: byte-addressed memory, rules straight from the ISA semantics.
    task automatic ref_op(input int w, input logic we, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er);
        int nb;
        logic ok;
        nb = (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
        ok = we ? (sz <= 3'd2) : (sz <= 3'd2 || sz == 3'd4 || sz == 3'd5);
        if (a % nb != 0) ok = 1'b0;
        if (a / 4 >= DEPTH) ok = 1'b0;
        rd = '0;
        er = !ok;
        if (ok) begin
            if (we) begin
                for (int i = 0; i < nb; i++) rmem[w][int'(a) + i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) rd = rd | (32'(rmem[w][int'(a) + i]) << (8*i));
                if (!sz[2] && nb < 4 && rd[8*nb-1]) rd = rd | ~((32'd1 << (8*nb)) - 32'd1);
            end
        end
    endtask

    // Present a request, wait for acceptance and then for resp_valid.
    // lat = sampling edges from acceptance to the first edge seeing resp_valid.
    task automatic txn_issue(input int w, input logic we, input logic [2:0] sz,
                             input logic [31:0] a, input logic [31:0] wd, output int lat);
        int n;
        @(negedge clk);
        rv[w] = 1'b1; rwe[w] = we; rsz[w] = sz; ra[w] = a; rwd[w] = wd;
        n = 0;
        while (rrdy[w] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        if (rrdy[w] !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout inst=%0d got req_ready=%b exp=1", w, rrdy[w]);
            rv[w] = 1'b0; lat = -1;
            return;
        end
        @(posedge clk);
        acc_t = $time;
        // Scramble inputs: the DUT must work from its latched copy.
        #1;
        rv[w] = 1'($urandom); rwe[w] = 1'($urandom); rsz[w] = 3'($urandom);
        ra[w] = $urandom; rwd[w] = $urandom;
        n = 0;
        @(negedge clk);
        while (rvld[w] !== 1'b1 && n < 50) begin @(posedge clk); n++; @(negedge clk); end
        if (rvld[w] !== 1'b1) begin
            total++; bad++;
            $display("FAIL resp_timeout inst=%0d got resp_valid=%b exp=1", w, rvld[w]);
            rv[w] = 1'b0; lat = -1;
            return;
        end
        lat = n + 1;
    endtask

    task automatic txn_finish(input int w, input int hold, output logic [31:0] rd, output logic er);
        repeat (hold) @(negedge clk);
        rd = rdat[w]; er = rerr[w];
        rv[w] = 1'b0; rrr[w] = 1'b1;
        @(posedge clk);
        hs_t = $time;
        #1 rrr[w] = 1'b0;
    endtask

    task automatic txn(input int w, input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input int hold,
                       output logic [31:0] rd, output logic er, output int lat);
        txn_issue(w, we, sz, a, wd, lat);
        txn_finish(w, hold, rd, er);
    endtask

    task automatic test_reset();
        for (int w = 0; w < 2; w++) begin
            total++; if (rrdy[w] !== 1'b1) begin bad++; $display("FAIL rst_req_ready inst=%0d got=%b exp=1", w, rrdy[w]); end
            total++; if (rvld[w] !== 1'b0) begin bad++; $display("FAIL rst_resp_valid inst=%0d got=%b exp=0", w, rvld[w]); end
            total++; if (rdat[w] !== 32'h0) begin bad++; $display("FAIL rst_rdata inst=%0d got=%h exp=0", w, rdat[w]); end
            total++; if (rerr[w] !== 1'b0) begin bad++; $display("FAIL rst_err inst=%0d got=%b exp=0", w, rerr[w]); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_resp got=%h/%b exp=0/0", rd, er); end
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 1, rd, er, lat);
        total++; if (lat != 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
        total++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_10 got=%h/%b exp=deadbeef/0", rd, er); end
    endtask

    task automatic test_ext();
        logic [31:0] rd; logic er; int lat;
        logic [2:0]  sz  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] ad  [5] = '{32'h23, 32'h23, 32'h22, 32'h20, 32'h20};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F01, 32'h80F1AA01};
        txn(0, 1'b1, 3'b010, 32'h20, 32'h80F17F01, 0, rd, er, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) txn(0, 1'b1, 3'b000, 32'h21, 32'h000000AA, 0, rd, er, lat);
            txn(0, 1'b0, sz[i], ad[i], 32'h0, 0, rd, er, lat);
            total++; if (er !== 1'b0 || rd !== exp[i]) begin bad++; $display("FAIL ext_%0d got=%h/%b exp=%h/0", i, rd, er, exp[i]); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b0, 3'b010, 32'h12, 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_lw_misalign got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b1, 3'b010, 32'h04, 32'h11223344, 0, rd, er, lat);
        txn(0, 1'b1, 3'b001, 32'h05, 32'h0000BEEF, 0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_sh_misalign got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b0, 3'b010, 32'h04, 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b0 || rd !== 32'h11223344) begin bad++; $display("FAIL err_sh_no_write got=%h/%b exp=11223344/0", rd, er); end
        txn(0, 1'b0, 3'b010, 32'(4*DEPTH), 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_range got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_funct3 got=%h/%b exp=0/1", rd, er); end
        txn(0, 1'b1, 3'b100, 32'h10, 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL err_store_funct3 got=%b exp=1", er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        txn_issue(0, 1'b0, 3'b010, 32'h10, 32'h0, lat);
        for (int i = 0; i < 5; i++) begin
            total++; if (rvld[0] !== 1'b1 || rdat[0] !== 32'hDEADBEEF || rrdy[0] !== 1'b0) begin
                bad++; $display("FAIL bp_hold_%0d got v=%b d=%h rdy=%b exp v=1 d=deadbeef rdy=0", i, rvld[0], rdat[0], rrdy[0]);
            end
            @(negedge clk);
        end
        txn_finish(0, 0, rd, er);
        total++; if (rvld[0] !== 1'b0 || rrdy[0] !== 1'b1) begin
            bad++; $display("FAIL bp_release got v=%b rdy=%b exp v=0 rdy=1", rvld[0], rrdy[0]);
        end
    endtask

    task automatic test_reset_wait();
        logic [31:0] rd; logic er; int lat;
        txn(0, 1'b1, 3'b010, 32'h30, 32'h0, 0, rd, er, lat);
        txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
        @(negedge clk);
        rv[0] = 1'b1; rwe[0] = 1'b1; rsz[0] = 3'b010; ra[0] = 32'h30; rwd[0] = 32'h12345678;
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        total++; if (rrdy[0] !== 1'b0) begin bad++; $display("FAIL rw_in_wait got req_ready=%b exp=0", rrdy[0]); end
        rst = 1'b0;
        #1;
        total++; if (rrdy[0] !== 1'b1 || rvld[0] !== 1'b0 || rdat[0] !== 32'h0 || rerr[0] !== 1'b0) begin
            bad++; $display("FAIL rw_clear got rdy=%b v=%b d=%h e=%b exp 1/0/0/0", rrdy[0], rvld[0], rdat[0], rerr[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        txn(0, 1'b0, 3'b010, 32'h30, 32'h0, 0, rd, er, lat);
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL rw_dropped got=%h/%b exp=0/0", rd, er); end
    endtask

    task automatic test_lat0();
        logic [31:0] rd; logic er; int lat;
        time hs_prev;
        txn(1, 1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 0, rd, er, lat);
        total++; if (lat != 1) begin bad++; $display("FAIL l0_sw_latency got=%0d exp=1", lat); end
        hs_prev = hs_t;
        txn(1, 1'b0, 3'b010, 32'h08, 32'h0, 0, rd, er, lat);
        total++; if (acc_t - hs_prev != 10) begin bad++; $display("FAIL l0_back_to_back got=%0t exp=10", acc_t - hs_prev); end
        total++; if (lat != 1) begin bad++; $display("FAIL l0_lw_latency got=%0d exp=1", lat); end
        total++; if (er !== 1'b0 || rd !== 32'hCAFEF00D) begin bad++; $display("FAIL l0_lw got=%h/%b exp=cafef00d/0", rd, er); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, a, wd; logic er, eer, we; logic [2:0] sz; int lat, r;
        logic [2:0] szl [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < DEPTH; i++) begin
                wd = $urandom;
                ref_op(w, 1'b1, 3'b010, 32'(4*i), wd, erd, eer);
                txn(w, 1'b1, 3'b010, 32'(4*i), wd, 0, rd, er, lat);
            end
            for (int i = 0; i < 120; i++) begin
                we = 1'($urandom);
                sz = ($urandom_range(0, 7) == 0) ? 3'($urandom) : szl[$urandom_range(0, 4)];
                r  = $urandom_range(0, 9);
                a  = (r == 0) ? $urandom : (r == 1) ? 32'(4*DEPTH + $urandom_range(0, 15))
                              : 32'($urandom_range(0, 4*DEPTH-1));
                wd = $urandom;
                ref_op(w, we, sz, a, wd, erd, eer);
                txn(w, we, sz, a, wd, $urandom_range(0, 2), rd, er, lat);
                total++; if (rd !== erd || er !== eer || lat != (w == 0 ? 3 : 1)) begin
                    bad++;
                    $display("FAIL rnd inst=%0d we=%b sz=%b a=%h got=%h/%b lat=%0d exp=%h/%b lat=%0d",
                             w, we, sz, a, rd, er, lat, erd, eer, (w == 0 ? 3 : 1));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int w = 0; w < 2; w++) begin
            rv[w] = 1'b0; rwe[w] = 1'b0; rsz[w] = '0; ra[w] = '0; rwd[w] = '0; rrr[w] = 1'b0;
        end
        #23;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_word();
        test_ext();
        test_errors();
        test_backpressure();
        test_reset_wait();
        test_lat0();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
